multi_pwm_generator: RTL

- Parametrised successor to the fixed 4-channel ESC pwm_generator.
- Generates N servo-style PWM outputs at a configurable frame period from N packed rate values.
- Double-buffers rates at frame boundaries, holds outputs at idle pulse while disarmed, and forces idle on a loss-of-update watchdog (failsafe).
- Sits between motor_mixer and the motor pins; clocked by sys_clk, timed by a single-cycle microsecond strobe from us_clk.

---
 rtl/multi_pwm_generator_pkg.sv | 14 +
 rtl/pwm_channel.sv | 41 ++++
 rtl/multi_pwm_generator.sv | 80 ++++++++
 3 files changed

// File: rtl/multi_pwm_generator_pkg.sv
// multi_pwm_generator_pkg: default timing constants and helpers shared by the PWM generator and its channels
package multi_pwm_generator_pkg;
  localparam int MOTOR_RATE_BIT_WIDTH = 8;
  localparam int PWM_CHANNELS = 4;
  localparam int PWM_PERIOD_US = 20000;
  localparam int PWM_MIN_US = 1000;
  localparam int PWM_MAX_US = 2000;
  localparam int PWM_SCALE = 4;
  localparam int PWM_TIMEOUT_FRAMES = 5;
  localparam int PWM_CNT_W = 16;
  function automatic int wd_width(input int frames);
    return (frames < 1) ? 1 : $clog2(frames + 1);
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: per-channel width compute, clamp, idle override, active width register and pulse compare
module pwm_channel
  import multi_pwm_generator_pkg::*;
#(
  parameter int RATE_W = MOTOR_RATE_BIT_WIDTH,
  parameter int CNT_W = PWM_CNT_W,
  parameter int MIN_US = PWM_MIN_US,
  parameter int MAX_US = PWM_MAX_US,
  parameter int SCALE = PWM_SCALE
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              i_wrap,
  input  logic              i_idle,
  input  logic              i_en,
  input  logic [RATE_W-1:0] i_rate,
  input  logic [CNT_W-1:0]  i_count,
  output logic              o_pwm
);
  localparam logic [CNT_W:0] MIN_X = (CNT_W+1)'(MIN_US);
  localparam logic [CNT_W:0] MAX_X = (CNT_W+1)'(MAX_US);
  logic [CNT_W:0] w_raw;
  logic [CNT_W-1:0] w_width;
  logic [CNT_W-1:0] r_active;
  logic r_pwm;
  // one spare bit so a large rate cannot wrap below the clamp ceiling
  always_comb begin
    w_raw = MIN_X + (CNT_W+1)'(i_rate) * (CNT_W+1)'(SCALE);
    w_width = i_idle ? CNT_W'(MIN_US) : (w_raw > MAX_X) ? CNT_W'(MAX_US) : w_raw[CNT_W-1:0];
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_active <= CNT_W'(MIN_US);
      r_pwm <= 1'b0;
    end else begin
      if (i_wrap) r_active <= w_width;
      r_pwm <= i_en && (i_count < r_active);
    end
  end
  assign o_pwm = r_pwm;
endmodule

// File: rtl/multi_pwm_generator.sv
// multi_pwm_generator: N-channel servo PWM with frame-synchronous rate latching, arm gating and update watchdog
module multi_pwm_generator
  import multi_pwm_generator_pkg::*;
#(
  parameter int CHANNELS = PWM_CHANNELS,
  parameter int RATE_W = MOTOR_RATE_BIT_WIDTH,
  parameter int PERIOD_US = PWM_PERIOD_US,
  parameter int MIN_US = PWM_MIN_US,
  parameter int MAX_US = PWM_MAX_US,
  parameter int SCALE = PWM_SCALE,
  parameter int TIMEOUT_FRAMES = PWM_TIMEOUT_FRAMES,
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       us_tick,
  input  logic                       arm,
  input  logic                       rate_valid,
  input  logic [CHANNELS*RATE_W-1:0] rate_in,
  output logic [CHANNELS-1:0]        pwm_out,
  output logic                       frame_start,
  output logic                       failsafe
);
  localparam int WD_W = wd_width(TIMEOUT_FRAMES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_FRAMES);
  logic [CNT_W-1:0] r_count;
  logic [WD_W-1:0] r_wd, w_wd_next;
  logic [CHANNELS*RATE_W-1:0] r_pending, w_rates;
  logic r_seen, r_started, r_frame_start, r_failsafe;
  logic w_wrap, w_fs_next, w_idle;
  logic [CHANNELS-1:0] w_pwm;
  // a strobe on the wrap cycle bypasses the pending latch and counts as received
  always_comb begin
    w_wrap = us_tick && (r_count == CNT_W'(PERIOD_US - 1));
    w_rates = rate_valid ? rate_in : r_pending;
    w_wd_next = rate_valid ? '0 : (r_wd == WD_MAX) ? r_wd : r_wd + WD_W'(1);
    w_fs_next = !(r_seen || rate_valid) || (w_wd_next == WD_MAX);
    w_idle = !arm || w_fs_next;
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_count <= '0;
      r_wd <= '0;
      r_pending <= '0;
      r_seen <= 1'b0;
      r_started <= 1'b0;
      r_frame_start <= 1'b0;
      r_failsafe <= 1'b1;
    end else begin
      if (us_tick) r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
      if (rate_valid || w_wrap) r_wd <= w_wd_next;
      if (rate_valid) r_pending <= rate_in;
      if (rate_valid) r_seen <= 1'b1;
      if (w_wrap) r_started <= 1'b1;
      if (w_wrap) r_failsafe <= w_fs_next;
      r_frame_start <= w_wrap;
    end
  end
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_channel #(
      .RATE_W(RATE_W),
      .CNT_W(CNT_W),
      .MIN_US(MIN_US),
      .MAX_US(MAX_US),
      .SCALE(SCALE)
    ) u_ch (
      .sys_clk(sys_clk),
      .reset(reset),
      .i_wrap(w_wrap),
      .i_idle(w_idle),
      .i_en(r_started),
      .i_rate(w_rates[k*RATE_W +: RATE_W]),
      .i_count(r_count),
      .o_pwm(w_pwm[k])
    );
  end
  assign pwm_out = w_pwm;
  assign frame_start = r_frame_start;
  assign failsafe = r_failsafe;
endmodule
